// File: rtl/fetch_if.sv
// Bus between the control stage and the balanced-ternary fetch unit.
// Every trit is two bits: 00=0, 01=+1, 10=-1, 11=illegal.
interface fetch_if #(
  parameter int ADDR_TRITS   = 9,
  parameter int INSTR_TRITS  = 9,
  parameter int OPCODE_TRITS = 3
);
  // Command strobes are level-sampled on every rising edge. There is no
  // valid/ready handshake: a strobe high at an edge is accepted at that edge,
  // imem_rdata must be valid in the same cycle, and results appear one cycle later.
  logic                      do_fetch;
  logic                      do_next;
  logic                      do_reset;
  logic                      do_halt;
  logic                      branch_taken;
  logic [2*INSTR_TRITS-1:0]  imem_rdata;
  logic [2*ADDR_TRITS-1:0]   imem_addr;
  logic [2*ADDR_TRITS-1:0]   pc;
  logic [2*INSTR_TRITS-1:0]  ir;
  logic [2*OPCODE_TRITS-1:0] opcode;
  logic                      is_alu_operation;
  logic                      pc_wrap;
  logic                      fetch_fault;

  modport master (
    output do_fetch, do_next, do_reset, do_halt, branch_taken, imem_rdata,
    input  imem_addr, pc, ir, opcode, is_alu_operation, pc_wrap, fetch_fault
  );

  modport slave (
    input  do_fetch, do_next, do_reset, do_halt, branch_taken, imem_rdata,
    output imem_addr, pc, ir, opcode, is_alu_operation, pc_wrap, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Balanced-ternary fetch stage: PC, instruction register and a one-cycle trit-serial PC adder.
// Defining FETCH_TRIT_CHECK_EN adds a sticky flag for illegal trits in fetched words.
module fetch_unit #(
  parameter int ADDR_TRITS   = 9,
  parameter int INSTR_TRITS  = 9,
  parameter int OPCODE_TRITS = 3,
  parameter int OFFSET_TRITS = 4
) (
  input logic    clock,
  input logic    reset,
  fetch_if.slave bus
);
  localparam int AW = 2 * ADDR_TRITS;
  localparam int IW = 2 * INSTR_TRITS;
  localparam int OW = 2 * OFFSET_TRITS;
  localparam int CW = 2 * OPCODE_TRITS;

  logic [AW-1:0] pc_q;
  logic [AW-1:0] operand;
  logic [AW-1:0] sum;
  logic [IW-1:0] ir_q;
  logic          wrap_q;
  logic          fault_q;
  logic          add_wrap;

  // Illegal 11 decodes as 0, so a corrupt pc or offset trit never propagates a bogus carry.
  function automatic int trit_val(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input int v);
    case (v)
      1:       return 2'b01;
      -1:      return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Increment is just an add of +1, so one adder serves both next and branch.
  assign operand = bus.branch_taken ? {{(AW-OW){1'b0}}, ir_q[OW-1:0]}
                                    : {{(AW-2){1'b0}}, 2'b01};

  always_comb begin
    int digit_sum;
    int carry;
    sum       = '0;
    carry     = 0;
    digit_sum = 0;
    for (int i = 0; i < ADDR_TRITS; i++) begin
      digit_sum = trit_val(pc_q[2*i +: 2]) + trit_val(operand[2*i +: 2]) + carry;
      if (digit_sum >= 2)       carry = 1;
      else if (digit_sum <= -2) carry = -1;
      else                      carry = 0;
      sum[2*i +: 2] = trit_enc(digit_sum - 3 * carry);
    end
    add_wrap = (carry != 0);
  end

  always_ff @(posedge clock) begin
    if (reset || bus.do_reset) begin
      pc_q   <= '0;
      ir_q   <= '0;
      wrap_q <= 1'b0;
    end else if (!bus.do_halt) begin
      if (bus.do_fetch) ir_q <= bus.imem_rdata;
      if (bus.do_next) begin
        pc_q <= sum;
        if (add_wrap) wrap_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_TRIT_CHECK_EN
  logic word_bad;

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < INSTR_TRITS; i++) begin
      if (bus.imem_rdata[2*i +: 2] == 2'b11) word_bad = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.do_reset) begin
      fault_q <= 1'b0;
    end else if (!bus.do_halt && bus.do_fetch && word_bad) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault_q = 1'b0;
`endif

  assign bus.imem_addr        = pc_q;
  assign bus.pc               = pc_q;
  assign bus.ir               = ir_q;
  assign bus.opcode           = ir_q[IW-1 -: CW];
  assign bus.is_alu_operation = (ir_q[IW-1 -: 2] == 2'b01);
  assign bus.pc_wrap          = wrap_q;
  assign bus.fetch_fault      = fault_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_TRITS, default 9: program counter width in trits; each trit is 2 bits (00=0, 01=+1, 10=-1, 11=illegal).
REQ-002 Parameter INSTR_TRITS, default 9: instruction word width in trits.
REQ-003 Parameter OPCODE_TRITS, default 3: opcode field width, taken from the most significant trits of the instruction.
REQ-004 Parameter OFFSET_TRITS, default 4: branch offset field width, taken from the least significant trits of the instruction.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  input  1  system clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 do_fetch  input  1  latch the instruction word into the instruction register (IR).
REQ-009 do_next  input  1  advance the PC.
REQ-010 do_reset  input  1  soft reset from the control stage.
REQ-011 do_halt  input  1  freeze the PC and IR.
REQ-012 branch_taken  input  1  branch condition, sampled only when do_next is high.
REQ-013 imem_rdata  input  2*INSTR_TRITS  instruction memory read data, combinational from imem_addr.
REQ-014 imem_addr  output  2*ADDR_TRITS  equals pc.
REQ-015 pc  output  2*ADDR_TRITS  current program counter.
REQ-016 ir  output  2*INSTR_TRITS  instruction register.
REQ-017 opcode  output  2*OPCODE_TRITS  top OPCODE_TRITS trits of ir.
REQ-018 is_alu_operation  output  1  high when the most significant opcode trit is +1 (01).
REQ-019 pc_wrap  output  1  sticky flag for PC wrap-around.
REQ-020 fetch_fault  output  1  sticky flag for an illegal trit in a fetched word (see Configuration).

Function
REQ-021 Priority on each rising edge, highest first: reset, do_reset, do_halt, then do_fetch/do_next.
REQ-022 do_fetch: ir <= imem_rdata on the same edge; opcode and is_alu_operation follow ir combinationally, so they are valid one cycle after do_fetch.
REQ-023 do_next with branch_taken=0: pc <= pc + 1 in balanced ternary. Per trit: 0+1=+1; -1+1=0; +1+1=-1 with carry +1.
REQ-024 do_next with branch_taken=1: pc <= pc + offset. Offset is ir[2*OFFSET_TRITS-1:0], extended to ADDR_TRITS by padding with 00 (balanced ternary needs no sign fill).
REQ-025 Branch addition is trit-serial in one cycle. Per trit sum s=a+b+cin lies in -3..3; digit=s-3*carry, with carry=+1 if s>=2, -1 if s<=-2, else 0.
REQ-026 Wrap-around: a nonzero carry out of the top trit is discarded and pc_wrap is set. pc_wrap stays set until reset/do_reset. Example: all +1 incremented gives all -1.
REQ-027 do_fetch and do_next in the same cycle: both act. ir loads from the old pc; pc advances using the old ir offset.
REQ-028 do_halt high: pc, ir and flags hold regardless of do_fetch/do_next.
REQ-029 Any illegal trit (11) in pc or in the offset arithmetic operand is treated as 0.
REQ-030 Latency: pc change visible on imem_addr one cycle after do_next; no stall path exists.

Reset
REQ-031 On reset or do_reset at a rising edge: pc=0 (all 00), ir=0, pc_wrap=0, fetch_fault=0, opcode=0, is_alu_operation=0.
REQ-032 Reset asserted mid-operation, coincident with do_fetch/do_next/do_halt, wins; no partial update occurs.

Configuration
REQ-033 Macro FETCH_TRIT_CHECK_EN defined: on do_fetch, if any trit of imem_rdata is 11, fetch_fault is set (sticky); ir still loads the raw word.
REQ-034 FETCH_TRIT_CHECK_EN undefined: the check logic is absent and fetch_fault is tied to 0.

Verification
REQ-035 Reset, then do_next x3 with branch_taken=0 -> pc trits (LSB first) go 0 -> +1 -> (-1,+1) -> (0,+1), i.e. values 1, 2, 3.
REQ-036 pc=all +1, do_next with branch_taken=0 -> pc=all -1 and pc_wrap=1; then do_reset -> pc=0, pc_wrap=0.
REQ-037 pc=5, ir offset=-4 (trits -1,-1,0,0 LSB first... i.e. value -4), do_next with branch_taken=1 -> pc=1; same with branch_taken=0 -> pc=6.
REQ-038 do_fetch with imem_rdata opcode top trit 01 -> next cycle is_alu_operation=1; do_halt plus do_fetch with a new word -> ir unchanged.
REQ-039 With FETCH_TRIT_CHECK_EN, do_fetch of a word containing 11 -> fetch_fault=1 and held; without the macro -> fetch_fault=0.
REQ-040 reset asserted in the same cycle as do_next and do_fetch -> pc=0 and ir=0 on the next cycle.
